// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one line-granular main_mem port between two caches.
// Serializes transactions, keeps a registered read-line buffer and a grant counter per port.
module mem_arbiter #(
    parameter int unsigned LINE_ADDR_LEN = 3,
    parameter int unsigned ADDR_LEN      = 10
) (
    input  logic                                  clk,
    input  logic                                  rst,

    input  logic                                  p0_rd_req,
    input  logic                                  p0_wr_req,
    input  logic [ADDR_LEN-1:0]                   p0_addr,
    input  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]   p0_wr_line,
    output logic                                  p0_gnt,
    output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]   p0_rd_line,
    output logic [31:0]                           p0_grant_cnt,

    input  logic                                  p1_rd_req,
    input  logic                                  p1_wr_req,
    input  logic [ADDR_LEN-1:0]                   p1_addr,
    input  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]   p1_wr_line,
    output logic                                  p1_gnt,
    output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]   p1_rd_line,
    output logic [31:0]                           p1_grant_cnt,

    output logic                                  mem_rd_req,
    output logic                                  mem_wr_req,
    output logic [ADDR_LEN-1:0]                   mem_addr,
    output logic [(1<<LINE_ADDR_LEN)-1:0][31:0]   mem_wr_line,
    input  logic                                  mem_gnt,
    input  logic [(1<<LINE_ADDR_LEN)-1:0][31:0]   mem_rd_line
);

    localparam int unsigned LineSize = 1 << LINE_ADDR_LEN;

    typedef logic [LineSize-1:0][31:0] line_t;
    typedef enum logic {StIdle, StBusy} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                op_wr_q, op_wr_d;
    logic                rr_next_q, rr_next_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    line_t               wr_line_q, wr_line_d;
    line_t               p0_rd_line_q, p0_rd_line_d;
    line_t               p1_rd_line_q, p1_rd_line_d;
    logic [31:0]         p0_cnt_q, p0_cnt_d;
    logic [31:0]         p1_cnt_q, p1_cnt_d;

    logic req0, req1, win;

    assign req0 = p0_rd_req | p0_wr_req;
    assign req1 = p1_rd_req | p1_wr_req;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        op_wr_d      = op_wr_q;
        rr_next_d    = rr_next_q;
        addr_d       = addr_q;
        wr_line_d    = wr_line_q;
        p0_rd_line_d = p0_rd_line_q;
        p1_rd_line_d = p1_rd_line_q;
        p0_cnt_d     = p0_cnt_q;
        p1_cnt_d     = p1_cnt_q;
        p0_gnt       = 1'b0;
        p1_gnt       = 1'b0;
        mem_rd_req   = 1'b0;
        mem_wr_req   = 1'b0;
        win          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    win       = (req0 & req1) ? rr_next_q : req1;
                    owner_d   = win;
                    addr_d    = win ? p1_addr : p0_addr;
                    wr_line_d = win ? p1_wr_line : p0_wr_line;
                    // Write beats read on the same port so a write-back precedes its fill.
                    op_wr_d   = win ? p1_wr_req : p0_wr_req;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                mem_wr_req = op_wr_q;
                mem_rd_req = ~op_wr_q;
                if (mem_gnt) begin
                    if (owner_q) begin
                        p1_gnt   = 1'b1;
                        p1_cnt_d = p1_cnt_q + 32'd1;
                        if (!op_wr_q) p1_rd_line_d = mem_rd_line;
                    end else begin
                        p0_gnt   = 1'b1;
                        p0_cnt_d = p0_cnt_q + 32'd1;
                        if (!op_wr_q) p0_rd_line_d = mem_rd_line;
                    end
                    rr_next_d = ~owner_q;
                    state_d   = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            op_wr_q      <= 1'b0;
            rr_next_q    <= 1'b0;
            addr_q       <= '0;
            wr_line_q    <= '0;
            p0_rd_line_q <= '0;
            p1_rd_line_q <= '0;
            p0_cnt_q     <= '0;
            p1_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            op_wr_q      <= op_wr_d;
            rr_next_q    <= rr_next_d;
            addr_q       <= addr_d;
            wr_line_q    <= wr_line_d;
            p0_rd_line_q <= p0_rd_line_d;
            p1_rd_line_q <= p1_rd_line_d;
            p0_cnt_q     <= p0_cnt_d;
            p1_cnt_q     <= p1_cnt_d;
        end
    end

    // Latched copies keep the downstream address and data stable across the whole transaction.
    assign mem_addr     = addr_q;
    assign mem_wr_line  = wr_line_q;
    assign p0_rd_line   = p0_rd_line_q;
    assign p1_rd_line   = p1_rd_line_q;
    assign p0_grant_cnt = p0_cnt_q;
    assign p1_grant_cnt = p1_cnt_q;

endmodule
